// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller turning a dual-port register file into a circular FIFO.
// Latency: flags, count and pointers update at the edge that accepts a push/pop; wr_en is combinational.
// Backpressure: pushes while full are dropped unless a pop happens on the same edge; pops while empty are ignored.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   wr, rd        - push / pop requests, sampled on the rising edge
//   wr_en         - write enable to the register file (sole write qualifier)
//   w_addr        - write pointer to the register file
//   r_addr        - read pointer (head entry) to the register file
//   full, empty   - occupancy flags
//   count         - occupancy, 0..2**W
//   ovf, udf      - sticky dropped-push / ignored-pop flags, present only with FIFO_ERR_FLAG_EN
//
// Optional feature macro: FIFO_ERR_FLAG_EN

module fifo_ctrl #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic         rd,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [W-1:0] r_addr,
  output logic         full,
  output logic         empty,
`ifdef FIFO_ERR_FLAG_EN
  output logic         ovf,
  output logic         udf,
`endif
  output logic [W:0]   count
);

  localparam logic [W:0]   DEPTH_C = {1'b1, {W{1'b0}}};
  localparam logic [W:0]   CNT_ONE = {{W{1'b0}}, 1'b1};
  localparam logic [W-1:0] PTR_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] w_addr_q, w_addr_d;
  logic [W-1:0] r_addr_q, r_addr_d;
  logic [W:0]   count_q, count_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  logic         push_ok;
  logic         pop_ok;

  // A push while full is still accepted when a pop frees the head slot on the
  // same edge: the consumer has already taken the old data, so the write may
  // land on the slot being vacated (w_addr == r_addr when full).
  always_comb begin
    push_ok  = wr & (~full_q | rd);
    pop_ok   = rd & ~empty_q;

    w_addr_d = push_ok ? (w_addr_q + PTR_ONE) : w_addr_q;
    r_addr_d = pop_ok  ? (r_addr_q + PTR_ONE) : r_addr_q;

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_addr_q <= '0;
      r_addr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      w_addr_q <= w_addr_d;
      r_addr_q <= r_addr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Gated by rst so the register file is never written while reset is held.
  assign wr_en  = wr & ~rst & (~full_q | rd);
  assign w_addr = w_addr_q;
  assign r_addr = r_addr_q;
  assign count  = count_q;
  assign full   = full_q;
  assign empty  = empty_q;

`ifdef FIFO_ERR_FLAG_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky until reset. An ignored pop counts even when paired with a push
  // into an empty FIFO.
  always_comb begin
    ovf_d = ovf_q | (wr & full_q & ~rd);
    udf_d = udf_q | (rd & empty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed self-checking bench for fifo_ctrl with a reference model and expected-state queue.
// Latency: expected state is queued when a step is driven and compared 1 time unit after the accepting edge.
// Backpressure: exercises dropped pushes when full, ignored pops when empty, and simultaneous push/pop.

module tb_fifo_ctrl;

  localparam int W = 3;
  localparam int DEPTH = 1 << W;

  logic         clk;
  logic         rst;
  logic         wr;
  logic         rd;
  logic         wr_en;
  logic [W-1:0] w_addr;
  logic [W-1:0] r_addr;
  logic         full;
  logic         empty;
  logic [W:0]   count;
`ifdef FIFO_ERR_FLAG_EN
  logic         ovf;
  logic         udf;
`endif

  fifo_ctrl #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .wr     (wr),
    .rd     (rd),
    .wr_en  (wr_en),
    .w_addr (w_addr),
    .r_addr (r_addr),
    .full   (full),
    .empty  (empty),
`ifdef FIFO_ERR_FLAG_EN
    .ovf    (ovf),
    .udf    (udf),
`endif
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int wa;
    int ra;
    int cnt;
    bit f;
    bit e;
    bit o;
    bit u;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_w, m_r, m_cnt;
  bit m_ovf, m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_r = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic check_state(input string tag, input exp_t e);
    check({tag, ".w_addr"}, 32'(w_addr), 32'(e.wa));
    check({tag, ".r_addr"}, 32'(r_addr), 32'(e.ra));
    check({tag, ".count"},  32'(count),  32'(e.cnt));
    check({tag, ".full"},   32'(full),   32'(e.f));
    check({tag, ".empty"},  32'(empty),  32'(e.e));
`ifdef FIFO_ERR_FLAG_EN
    check({tag, ".ovf"},    32'(ovf),    32'(e.o));
    check({tag, ".udf"},    32'(udf),    32'(e.u));
`endif
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.wa  = m_w;
    e.ra  = m_r;
    e.cnt = m_cnt;
    e.f   = (m_cnt == DEPTH);
    e.e   = (m_cnt == 0);
    e.o   = m_ovf;
    e.u   = m_udf;
    return e;
  endfunction

  // Called at posedge+1; drives one request pair, checks wr_en before the
  // edge, queues the model's post-edge state and compares it after the edge.
  task automatic step(input string tag, input bit w, input bit r);
    exp_t e;
    bit   m_full, m_empty, push, pop;
    wr = w;
    rd = r;
    #1;
    m_full  = (m_cnt == DEPTH);
    m_empty = (m_cnt == 0);
    push = w && (!m_full || r);
    pop  = r && !m_empty;
    check({tag, ".wr_en"}, 32'(wr_en), 32'(push));
    if (w && m_full && !r) m_ovf = 1;
    if (r && m_empty)      m_udf = 1;
    if (push) m_w = (m_w + 1) % DEPTH;
    if (pop)  m_r = (m_r + 1) % DEPTH;
    m_cnt = m_cnt + int'(push) - int'(pop);
    exp_q.push_back(model_snapshot());
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_state(tag, e);
    end
  endtask

  // Called at posedge+1; asserts rst between edges with the given wr value and
  // checks that state clears without waiting for a clock edge.
  task automatic reset_mid(input string tag, input bit w);
    exp_t e;
    wr = w;
    rd = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    e = model_snapshot();
    check_state(tag, e);
    check({tag, ".wr_en"}, 32'(wr_en), 32'd0);
    @(posedge clk);
    #1;
    wr  = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr  = 1'b0;
    rd  = 1'b0;
    model_reset();
    #1;
    check_state("rst0", model_snapshot());
    check("rst0.wr_en", 32'(wr_en), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) step($sformatf("idle%0d", i), 1'b0, 1'b0);

    // Fill to full; pointer wraps back to 0
    for (int i = 0; i < DEPTH; i++) step($sformatf("push%0d", i), 1'b1, 1'b0);
    check("fill.full_final", 32'(full), 32'd1);
    check("fill.w_addr_wrap", 32'(w_addr), 32'd0);

    // Dropped push while full
    step("drop", 1'b1, 1'b0);

    // Simultaneous push/pop while full, 3 cycles
    for (int i = 0; i < 3; i++) step($sformatf("fullrw%0d", i), 1'b1, 1'b1);
    check("fullrw.w_addr", 32'(w_addr), 32'd3);
    check("fullrw.r_addr", 32'(r_addr), 32'd3);

    // Drain to empty, then ignored pop
    for (int i = 0; i < DEPTH; i++) step($sformatf("drain%0d", i), 1'b0, 1'b1);
    step("pop_empty", 1'b0, 1'b1);

    // From empty after reset: push+pop together is write-only
    reset_mid("rst1", 1'b0);
    step("emptyrw", 1'b1, 1'b1);
    check("emptyrw.count", 32'(count), 32'd1);
    step("emptyrw_pop", 1'b0, 1'b1);
    step("mix_push", 1'b1, 1'b0);
    step("mix_rw", 1'b1, 1'b1);

    // 5 pushes, 5 pops, then reset mid-cycle during a push
    reset_mid("rst2", 1'b0);
    for (int i = 0; i < 5; i++) step($sformatf("p5_%0d", i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step($sformatf("q5_%0d", i), 1'b0, 1'b1);
    reset_mid("rst_mid", 1'b1);
    step("post_rst", 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
